// File: rtl/aes_pkg.sv
// aes_pkg: shared AES decryption types, round-count constants and GF(2^8) helpers
package aes_pkg;
  typedef logic [127:0] aes_state_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} aes_dec_state_e;
  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction
  // multiplicative inverse as a^254; maps 0 to 0 as AES requires
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, s;
    p = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      p = gmul(p, s);
    end
    return p;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return ginv({b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05);
  endfunction
endpackage

// File: rtl/aes_inv_blocks.sv
// aes_inv_blocks: combinational InvShiftRows, InvSubBytes and InvMixColumns (byte 0 in bits [127:120])
module inv_shift_rows (
  input  logic [127:0] a,
  output logic [127:0] y
);
  for (genvar i = 0; i < 16; i++) begin : g_b
    localparam int S = (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4);
    assign y[127-8*i -: 8] = a[127-8*S -: 8];
  end
endmodule

module inv_sub_byte
  import aes_pkg::*;
(
  input  logic [127:0] a,
  output logic [127:0] y
);
  for (genvar i = 0; i < 16; i++) begin : g_b
    assign y[127-8*i -: 8] = inv_sbox(a[127-8*i -: 8]);
  end
endmodule

module inv_mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] a,
  output logic [127:0] y
);
  for (genvar c = 0; c < 4; c++) begin : g_c
    logic [7:0] a0, a1, a2, a3;
    assign a0 = a[127-32*c -: 8];
    assign a1 = a[119-32*c -: 8];
    assign a2 = a[111-32*c -: 8];
    assign a3 = a[103-32*c -: 8];
    assign y[127-32*c -: 32] = {
      gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
      gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
      gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
      gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  end
endmodule

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational inverse round; mix-columns bypassed on the last round
module aes_inv_round (
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] result
);
  logic [127:0] sr, sb, ak, mc;
  inv_shift_rows  u_sr (.a(state), .y(sr));
  inv_sub_byte    u_sb (.a(sr),    .y(sb));
  assign ak = sb ^ rk;
  inv_mix_columns u_mc (.a(ak),    .y(mc));
  assign result = last ? ak : mc;
endmodule

// File: rtl/aes_inv_round_ctrl.sv
// aes_inv_round_ctrl: iterative AES decryptor, one inverse round per clock with external round-key fetch
module aes_inv_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR  = 10,
  parameter int KIW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_data,
  output logic [KIW-1:0] key_idx,
  input  logic [127:0]   rk,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_data,
  output logic           busy
);
  localparam logic [KIW-1:0] KNR = KIW'(NR);
  localparam logic [KIW-1:0] ONE = KIW'(1);
  aes_dec_state_e fsm, fsm_nx;
  aes_state_t st, st_nx, rnd;
  logic [KIW-1:0] cnt, cnt_nx;
  aes_inv_round u_round (.state(st), .rk(rk), .last(fsm == FINAL), .result(rnd));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= IDLE;
      st  <= '0;
      cnt <= '0;
    end else begin
      fsm <= fsm_nx;
      st  <= st_nx;
      cnt <= cnt_nx;
    end
  end
  // abort overrides every transition below, including both handshakes
  always_comb begin
    fsm_nx = fsm;
    st_nx  = st;
    cnt_nx = cnt;
    unique case (fsm)
      IDLE: if (in_valid) begin
        st_nx  = in_data ^ rk;
        cnt_nx = KNR - ONE;
        fsm_nx = ROUND;
      end
      ROUND: begin
        st_nx  = rnd;
        cnt_nx = (cnt == ONE) ? cnt : cnt - ONE;
        fsm_nx = (cnt == ONE) ? FINAL : ROUND;
      end
      FINAL: begin
        st_nx  = rnd;
        fsm_nx = DONE;
      end
      DONE: fsm_nx = out_ready ? IDLE : DONE;
    endcase
    if (abort) begin
      fsm_nx = IDLE;
      st_nx  = st;
      cnt_nx = '0;
    end
  end
  assign in_ready  = fsm == IDLE;
  assign busy      = (fsm == ROUND) || (fsm == FINAL);
  assign out_valid = fsm == DONE;
  assign out_data  = st;
  assign key_idx   = (fsm == IDLE) ? KNR : (fsm == ROUND) ? cnt : '0;
endmodule
